// File: rtl/arb_muxn_pkg.sv
// Shared arbitration-mode constants and width helpers for parametrised datapath blocks.
package arb_muxn_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Channel-index width; never zero so a single channel still has a legal select bus.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/arb_muxn_rr_arbiter.sv
// Combinational arbiter: one-hot grant plus its index from requests and the rotation pointer.
// Latency: zero cycles, purely combinational.
// Backpressure: enable=0 forces grant to zero; grant_idx still reports the would-be winner.
module rr_arbiter
  import arb_muxn_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_FIXED,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic found;
  int   idx;

  // Search order starts at ptr in round-robin mode, at 0 otherwise; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (MODE == ARB_RR) ? int'(ptr) + k : k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = SELW'(idx);
      end
    end
    if (found && enable) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/arb_muxn.sv
// N-channel arbitrating mux with a one-entry registered output stage.
// Latency: 1 cycle from accepted input to out_valid; 1 word/cycle under continuous out_ready.
// Backpressure: while out_valid && !out_ready all in_ready are 0 and output/pointer are frozen.
module arb_muxn
  import arb_muxn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = ARB_FIXED,
  localparam int SELW = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid || out_ready;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .enable    (load_en && !reset),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only ever raised on a valid channel, so any grant bit is a transfer.
  assign in_ready = grant;
  assign xfer     = |grant;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        if (MODE == ARB_RR) begin
          ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_muxn.sv
// Directed plus random checks of arb_muxn in fixed-priority (N=4) and round-robin (N=3) builds.
module tb_arb_muxn;

  logic         clk;
  logic         reset;
  logic [127:0] in_data0;
  logic [3:0]   in_valid0;
  logic [3:0]   in_ready0;
  logic [31:0]  out_data0;
  logic [1:0]   out_sel0;
  logic         out_valid0;
  logic         out_ready0;
  logic [95:0]  in_data1;
  logic [2:0]   in_valid1;
  logic [2:0]   in_ready1;
  logic [31:0]  out_data1;
  logic [1:0]   out_sel1;
  logic         out_valid1;
  logic         out_ready1;

  int checks = 0;
  int errors = 0;

  // Reference state: held word per DUT plus rotation pointer as plain integers.
  int          nn[2]   = '{4, 3};
  int          mmode[2] = '{0, 1};
  int          mv[2];
  int          mp[2];
  int          ms[2];
  logic [31:0] md[2];
  logic [3:0]  last_rdy0;
  logic [2:0]  last_rdy1;

  arb_muxn #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_sel(out_sel0),
    .out_valid(out_valid0), .out_ready(out_ready0)
  );

  arb_muxn #(.WIDTH(32), .N(3), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [15:0] v, input int p, input int n, input int mode);
    int i;
    for (int k = 0; k < n; k++) begin
      i = (mode == 1) ? (p + k) % n : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    int          w;
    int          nv[2];
    int          np[2];
    int          ns[2];
    logic [31:0] nd[2];
    logic [15:0] v;
    logic [15:0] er;
    logic [511:0] dt;
    logic        rdy;
    bit          ld;
    #1;
    for (int d = 0; d < 2; d++) begin
      v   = (d == 0) ? 16'(in_valid0) : 16'(in_valid1);
      dt  = (d == 0) ? 512'(in_data0) : 512'(in_data1);
      rdy = (d == 0) ? out_ready0 : out_ready1;
      nv[d] = mv[d]; np[d] = mp[d]; ns[d] = ms[d]; nd[d] = md[d];
      ld = (mv[d] == 0) || rdy;
      w  = ld ? winner(v, mp[d], nn[d], mmode[d]) : -1;
      er = '0;
      if (reset) begin
        nv[d] = 0; np[d] = 0; ns[d] = 0; nd[d] = '0;
      end else if (w >= 0) begin
        er[w] = 1'b1;
        nv[d] = 1; ns[d] = w; nd[d] = dt[w*32 +: 32];
        if (mmode[d] == 1) np[d] = (w + 1) % nn[d];
      end else if (mv[d] != 0 && rdy) begin
        nv[d] = 0;
      end
      if (d == 0) check("in_ready0", 32'(in_ready0), 32'(er));
      else        check("in_ready1", 32'(in_ready1), 32'(er));
    end
    last_rdy0 = in_ready0;
    last_rdy1 = in_ready1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mv[d] = nv[d]; mp[d] = np[d]; ms[d] = ns[d]; md[d] = nd[d];
    end
    check("out_valid0", 32'(out_valid0), 32'(mv[0]));
    check("out_data0",  out_data0,       md[0]);
    check("out_sel0",   32'(out_sel0),   32'(ms[0]));
    check("out_valid1", 32'(out_valid1), 32'(mv[1]));
    check("out_data1",  out_data1,       md[1]);
    check("out_sel1",   32'(out_sel1),   32'(ms[1]));
    @(negedge clk);
  endtask

  initial begin
    int rr_exp[6];
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; mp[d] = 0; ms[d] = 0; md[d] = '0;
    end
    for (int i = 0; i < 4; i++) in_data0[i*32 +: 32] = 32'h100 + i;
    for (int i = 0; i < 3; i++) in_data1[i*32 +: 32] = 32'h200 + i;

    // Reset held with every channel requesting.
    reset = 1'b1;
    in_valid0 = 4'hF; in_valid1 = 3'h7;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    repeat (2) begin
      cycle();
      check("rst_rdy0", 32'(last_rdy0), 32'h0);
      check("rst_rdy1", 32'(last_rdy1), 32'h0);
      check("rst_valid0", 32'(out_valid0), 32'h0);
      check("rst_data0", out_data0, 32'h0);
      check("rst_sel1", 32'(out_sel1), 32'h0);
    end
    reset = 1'b0;
    cycle();
    check("first_sel0", 32'(out_sel0), 32'h0);
    check("first_sel1", 32'(out_sel1), 32'h0);
    check("first_data0", out_data0, 32'h100);

    // Fixed priority: channel 1 beats channel 3 every cycle.
    in_valid0 = 4'b1010;
    in_data0[32 +: 32] = 32'hA1;
    in_data0[96 +: 32] = 32'hA3;
    repeat (4) begin
      cycle();
      check("fp_rdy", 32'(last_rdy0), 32'b0010);
      check("fp_sel", 32'(out_sel0), 32'h1);
      check("fp_data", out_data0, 32'hA1);
    end

    // Round robin from a fresh pointer: 0,1,2,0,1,2.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rr_exp = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_sel", 32'(out_sel1), 32'(rr_exp[k]));
    end

    // Backpressure: hold 0x55 from channel 1 (pointer then at 2).
    in_valid1 = 3'b010;
    in_data1[32 +: 32] = 32'h55;
    cycle();
    check("bp_load", out_data1, 32'h55);
    in_valid1 = 3'b111;
    in_data1[64 +: 32] = 32'h66;
    out_ready1 = 1'b0;
    repeat (3) begin
      cycle();
      check("bp_rdy", 32'(last_rdy1), 32'h0);
      check("bp_data", out_data1, 32'h55);
      check("bp_sel", 32'(out_sel1), 32'h1);
    end
    out_ready1 = 1'b1;
    cycle();
    check("bp_reload_rdy", 32'(last_rdy1), 32'b100);
    check("bp_reload_data", out_data1, 32'h66);
    check("bp_reload_valid", 32'(out_valid1), 32'h1);

    // Drain without reload on the fixed-priority build.
    in_valid0 = 4'b0001;
    in_data0[0 +: 32] = 32'h77;
    cycle();
    in_valid0 = 4'b0000;
    cycle();
    check("drain_valid", 32'(out_valid0), 32'h0);
    check("drain_data", out_data0, 32'h77);

    // Reset while a word is held and the pointer sits at 2.
    in_valid1 = 3'b010;
    cycle();
    reset = 1'b1;
    in_valid1 = 3'b000;
    out_ready1 = 1'b0;
    cycle();
    check("mrst_valid", 32'(out_valid1), 32'h0);
    reset = 1'b0;
    repeat (2) begin
      cycle();
      check("mrst_idle", 32'(out_valid1), 32'h0);
    end
    in_valid1 = 3'b111;
    out_ready1 = 1'b1;
    cycle();
    check("mrst_ptr_rdy", 32'(last_rdy1), 32'b001);
    check("mrst_ptr_sel", 32'(out_sel1), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 59) == 0);
      in_valid0  = 4'($urandom);
      in_valid1  = 3'($urandom);
      out_ready0 = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data0[i*32 +: 32] = $urandom;
      for (int i = 0; i < 3; i++) in_data1[i*32 +: 32] = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_muxn.md
# arb_muxn

Parametrised N-channel arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port. It replaces fixed-select combinational steering wherever several datapath producers share one consumer across cycles, such as result writeback, memory-request merging or bus sharing. Arbitration is either fixed-priority or round-robin. The selected word is held in a one-entry output register that sustains one transfer per cycle under continuous demand.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels, 1..16
- MODE, 0, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round robin
- SELW (localparam), max(1, clog2(N)), width of channel index
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel request
- in_ready  output  N  per-channel accept; combinational
- out_data  output  WIDTH  registered selected word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts the word

## Operation
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready=0 while reset is high.
- load_en = !out_valid || out_ready.
- Grant is one-hot, combinational from in_valid and ptr.
  - MODE 0: lowest-index valid channel wins.
  - MODE 1: first valid channel at or after ptr wins, searching ptr, ptr+1, …, N-1, 0, ….
- in_ready[i] = grant[i] && load_en && !reset. At most one bit is high.
- Transfer on channel i when in_valid[i] && in_ready[i]. On that edge: out_data<=in_data[i], out_sel<=i, out_valid<=1.
- MODE 1 only: on a transfer, ptr <= (i == N-1) ? 0 : i+1. Wrap is correct for non-power-of-2 N. ptr is unchanged when no transfer occurs. In MODE 0, ptr stays 0.
- Output drain: if out_valid && out_ready and no load occurs, out_valid<=0. out_data and out_sel keep their last values.
- Simultaneous drain and load: the new word replaces the old one and out_valid stays 1, giving full throughput.
- Backpressure: while out_valid && !out_ready, out_data and out_sel are stable, all in_ready bits are 0, and ptr is frozen.
- No valid inputs: no grant, and state changes only by drain.
- Reset mid-operation: any held word is discarded and ptr returns to 0 on the next edge.
- N=1: grant = in_valid[0], out_sel is constant 0, and MODE has no effect.

## Timing
- Latency is 1 cycle from an accepted input to out_valid.
- Throughput is 1 word/cycle with continuous out_ready.
- in_ready depends combinationally on in_valid, out_ready and registers. There is no combinational path from in_data to any output.
- out_* are driven directly from flops.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once per N consecutive cycles.

## Structure
- Shared header/package: arbitration-mode constants ARB_FIXED=0 and ARB_RR=1, and a clog2 function reused by other parametrised datapath blocks.
- Sub-module rr_arbiter (params N, MODE): inputs req[N], ptr, enable; outputs grant[N] and grant_idx[SELW]. It is purely combinational. The top level owns ptr, the output register and the handshake.
- Data selection is an AND-OR reduction over the grant one-hot, not a priority chain.

## Test plan
- Reset: drive reset for 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_sel=0 throughout; after release, first grant goes to channel 0.
- Fixed priority (MODE 0, N=4): in_valid=4'b1010 with data 0xA1/0xA3 on channels 1/3 and out_ready=1. Required: channel 1 accepted every cycle, out_sel=1, out_data=0xA1 one cycle later; channel 3 is starved while channel 1 stays valid.
- Round robin (MODE 1, N=3): all channels valid with out_ready=1 for 6 cycles. Required: out_sel sequence 0,1,2,0,1,2; ptr wraps from 2 to 0.
- Backpressure: out_ready=0 for 3 cycles with word 0x55 held. Required: out_data=0x55 and out_sel stable, in_ready=0, ptr unchanged. On out_ready=1, same-cycle reload of the next word and out_valid stays 1.
- Drain without reload: single word 0x77, then in_valid=0 and out_ready=1. Required: out_valid falls the next cycle and out_data stays 0x77.
- Reset mid-operation: assert reset while out_valid=1 and ptr=2. Required: out_valid=0 and ptr=0 next edge; no held word appears after release.
